// File: rtl/cube_scan_sequencer.sv
// rtl/cube_scan_sequencer.sv - face scan sequencer: move, settle, average, two-pass colour translate, store
// Optional feature macro: SCAN_TIMEOUT_EN (move timeout with sticky error flag)
module cube_scan_sequencer #(
    parameter int NUM_POS        = 4,
    parameter int LOG2_SAMPLES   = 2,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       move_req,
    output logic [2:0] move_pos,
    input  logic       move_done,
    input  logic       sample_valid,
    input  logic [7:0] s_r_edge,
    input  logic [7:0] s_g_edge,
    input  logic [7:0] s_b_edge,
    input  logic [7:0] s_r_corner,
    input  logic [7:0] s_g_corner,
    input  logic [7:0] s_b_corner,
    output logic [7:0] tr_r_edge,
    output logic [7:0] tr_g_edge,
    output logic [7:0] tr_b_edge,
    output logic [7:0] tr_r_corner,
    output logic [7:0] tr_g_corner,
    output logic [7:0] tr_b_corner,
    output logic [2:0] tr_known_edge_color,
    input  logic [2:0] tr_color_edge,
    input  logic [2:0] tr_color_corner,
    output logic       res_we,
    output logic [3:0] res_addr,
    output logic [2:0] res_data
);

    localparam int AW = 8 + LOG2_SAMPLES;
    localparam int CW = LOG2_SAMPLES + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << LOG2_SAMPLES) - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    LAST_POS    = 3'(NUM_POS - 1);
    localparam logic [2:0]    UNKNOWN     = 3'd7;

    typedef enum logic [3:0] {
        IDLE,
        MOVE,
        SETTLE,
        SAMPLE,
        EDGE_EVAL,
        EDGE_CAP,
        CORNER_EVAL,
        CORNER_CAP,
        FINISH
    } state_t;

    state_t        state;
    logic [2:0]    pos;
    logic [SW-1:0] settle_cnt;
    logic [CW-1:0] sample_cnt;
    logic [AW-1:0] acc_r_edge, acc_g_edge, acc_b_edge;
    logic [AW-1:0] acc_r_corner, acc_g_corner, acc_b_corner;
    logic [AW-1:0] sum_r_edge, sum_g_edge, sum_b_edge;
    logic [AW-1:0] sum_r_corner, sum_g_corner, sum_b_corner;

`ifdef SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timeout_cnt;
`else
    assign error = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Running sums including the sample presented this cycle, so the last
    // sample can feed the average without an extra accumulate cycle.
    assign sum_r_edge   = acc_r_edge   + AW'(s_r_edge);
    assign sum_g_edge   = acc_g_edge   + AW'(s_g_edge);
    assign sum_b_edge   = acc_b_edge   + AW'(s_b_edge);
    assign sum_r_corner = acc_r_corner + AW'(s_r_corner);
    assign sum_g_corner = acc_g_corner + AW'(s_g_corner);
    assign sum_b_corner = acc_b_corner + AW'(s_b_corner);

    // Scan state machine with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            pos                 <= 3'd0;
            settle_cnt          <= '0;
            sample_cnt          <= '0;
            acc_r_edge          <= '0;
            acc_g_edge          <= '0;
            acc_b_edge          <= '0;
            acc_r_corner        <= '0;
            acc_g_corner        <= '0;
            acc_b_corner        <= '0;
            done                <= 1'b0;
            move_req            <= 1'b0;
            move_pos            <= 3'd0;
            tr_r_edge           <= 8'd0;
            tr_g_edge           <= 8'd0;
            tr_b_edge           <= 8'd0;
            tr_r_corner         <= 8'd0;
            tr_g_corner         <= 8'd0;
            tr_b_corner         <= 8'd0;
            tr_known_edge_color <= UNKNOWN;
            res_we              <= 1'b0;
            res_addr            <= 4'd0;
            res_data            <= 3'd0;
`ifdef SCAN_TIMEOUT_EN
            error               <= 1'b0;
            timeout_cnt         <= '0;
`endif
        end else begin
            move_req <= 1'b0;
            res_we   <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pos      <= 3'd0;
                        move_req <= 1'b1;
                        move_pos <= 3'd0;
                        state    <= MOVE;
`ifdef SCAN_TIMEOUT_EN
                        error       <= 1'b0;
                        timeout_cnt <= '0;
`endif
                    end
                end
                MOVE: begin
                    // move_done wins over a timeout expiring in the same cycle
                    if (move_done) begin
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
`ifdef SCAN_TIMEOUT_EN
                    else if (timeout_cnt == LAST_TIMEOUT) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
`endif
                end
                SETTLE: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        acc_r_edge   <= '0;
                        acc_g_edge   <= '0;
                        acc_b_edge   <= '0;
                        acc_r_corner <= '0;
                        acc_g_corner <= '0;
                        acc_b_corner <= '0;
                        sample_cnt   <= '0;
                        state        <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                SAMPLE: begin
                    if (sample_valid) begin
                        acc_r_edge   <= sum_r_edge;
                        acc_g_edge   <= sum_g_edge;
                        acc_b_edge   <= sum_b_edge;
                        acc_r_corner <= sum_r_corner;
                        acc_g_corner <= sum_g_corner;
                        acc_b_corner <= sum_b_corner;
                        if (sample_cnt == LAST_SAMPLE) begin
                            tr_r_edge           <= 8'(sum_r_edge   >> LOG2_SAMPLES);
                            tr_g_edge           <= 8'(sum_g_edge   >> LOG2_SAMPLES);
                            tr_b_edge           <= 8'(sum_b_edge   >> LOG2_SAMPLES);
                            tr_r_corner         <= 8'(sum_r_corner >> LOG2_SAMPLES);
                            tr_g_corner         <= 8'(sum_g_corner >> LOG2_SAMPLES);
                            tr_b_corner         <= 8'(sum_b_corner >> LOG2_SAMPLES);
                            tr_known_edge_color <= UNKNOWN;
                            state               <= EDGE_EVAL;
                        end else begin
                            sample_cnt <= sample_cnt + CW'(1);
                        end
                    end
                end
                EDGE_EVAL: begin
                    state <= EDGE_CAP;
                end
                EDGE_CAP: begin
                    // edge colour is both stored and fed back for the corner pass
                    res_we              <= 1'b1;
                    res_addr            <= {pos, 1'b0};
                    res_data            <= tr_color_edge;
                    tr_known_edge_color <= tr_color_edge;
                    state               <= CORNER_EVAL;
                end
                CORNER_EVAL: begin
                    state <= CORNER_CAP;
                end
                CORNER_CAP: begin
                    res_we   <= 1'b1;
                    res_addr <= {pos, 1'b1};
                    res_data <= tr_color_corner;
                    if (pos == LAST_POS) begin
                        state <= FINISH;
                    end else begin
                        pos      <= pos + 3'd1;
                        move_req <= 1'b1;
                        move_pos <= pos + 3'd1;
                        state    <= MOVE;
`ifdef SCAN_TIMEOUT_EN
                        timeout_cnt <= '0;
`endif
                    end
                end
                FINISH: begin
                    done                <= 1'b1;
                    tr_known_edge_color <= UNKNOWN;
                    state               <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cube_scan_sequencer.sv
// tb/tb_cube_scan_sequencer.sv - randomized self-checking bench for cube_scan_sequencer
module tb_cube_scan_sequencer;

    localparam int NP = 4;
    localparam int LS = 2;
    localparam int NS = 1 << LS;
    localparam int ST = 4;
    localparam int TO = 50;

    logic clock = 1'b0;
    logic reset, start, move_done, sample_valid;
    logic [7:0] s_r_edge, s_g_edge, s_b_edge, s_r_corner, s_g_corner, s_b_corner;
    logic busy, done, error, move_req, res_we;
    logic [2:0] move_pos, tr_known_edge_color, tr_color_edge, tr_color_corner, res_data;
    logic [7:0] tr_r_edge, tr_g_edge, tr_b_edge, tr_r_corner, tr_g_corner, tr_b_corner;
    logic [3:0] res_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    cube_scan_sequencer #(.NUM_POS(NP), .LOG2_SAMPLES(LS), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .move_req(move_req), .move_pos(move_pos), .move_done(move_done), .sample_valid(sample_valid),
        .s_r_edge(s_r_edge), .s_g_edge(s_g_edge), .s_b_edge(s_b_edge),
        .s_r_corner(s_r_corner), .s_g_corner(s_g_corner), .s_b_corner(s_b_corner),
        .tr_r_edge(tr_r_edge), .tr_g_edge(tr_g_edge), .tr_b_edge(tr_b_edge),
        .tr_r_corner(tr_r_corner), .tr_g_corner(tr_g_corner), .tr_b_corner(tr_b_corner),
        .tr_known_edge_color(tr_known_edge_color), .tr_color_edge(tr_color_edge),
        .tr_color_corner(tr_color_corner), .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // stub translator: edge colour from red edge low bits, corner = known edge + 1
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            tr_color_edge   <= 3'd0;
            tr_color_corner <= 3'd0;
        end else begin
            tr_color_edge   <= tr_r_edge[2:0];
            tr_color_corner <= tr_known_edge_color + 3'd1;
        end
    end

    typedef struct {
        int         cyc;
        logic [3:0] addr;
        logic [2:0] data;
        logic [2:0] kn_now;
        logic [2:0] kn_eval;
        logic [5:0][7:0] avg;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  mq[$];
    logic [2:0] kn1, kn2;

    // observe result writes, done pulses and move requests
    always @(negedge clock) begin
        wr_t w;
        if (res_we) begin
            w.cyc     = cyc;
            w.addr    = res_addr;
            w.data    = res_data;
            w.kn_now  = tr_known_edge_color;
            w.kn_eval = kn2;
            w.avg[0]  = tr_r_edge;
            w.avg[1]  = tr_g_edge;
            w.avg[2]  = tr_b_edge;
            w.avg[3]  = tr_r_corner;
            w.avg[4]  = tr_g_corner;
            w.avg[5]  = tr_b_corner;
            wq.push_back(w);
        end
        if (done) dq.push_back(cyc);
        if (move_req) mq.push_back(int'(move_pos));
        kn2 <= kn1;
        kn1 <= tr_known_edge_color;
    end

    logic [7:0] smp [NP][6][NS];
    logic [7:0] exp_avg [NP][6];
    logic [2:0] exp_dat [2*NP];

    task automatic randomize_samples();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 6; c++)
                for (int k = 0; k < NS; k++)
                    smp[p][c][k] = 8'($urandom_range(0, 255));
    endtask

    task automatic build_model();
        int s;
        for (int p = 0; p < NP; p++) begin
            for (int c = 0; c < 6; c++) begin
                s = 0;
                for (int k = 0; k < NS; k++) s += int'(smp[p][c][k]);
                exp_avg[p][c] = 8'(s / NS);
            end
            exp_dat[2*p]     = exp_avg[p][0][2:0];
            exp_dat[2*p + 1] = 3'((int'(exp_dat[2*p]) + 1) % 8);
        end
    endtask

    task automatic set_samples(input int p, input int k);
        s_r_edge   = smp[p][0][k];
        s_g_edge   = smp[p][1][k];
        s_b_edge   = smp[p][2][k];
        s_r_corner = smp[p][3][k];
        s_g_corner = smp[p][4][k];
        s_b_corner = smp[p][5][k];
    endtask

    task automatic set_junk();
        s_r_edge   = 8'hff;
        s_g_edge   = 8'hff;
        s_b_edge   = 8'hff;
        s_r_corner = 8'hff;
        s_g_corner = 8'hff;
        s_b_corner = 8'hff;
    endtask

    task automatic clear_logs();
        wq.delete();
        dq.delete();
        mq.delete();
    endtask

    task automatic wait_move_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (move_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #1;
            if (dq.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Plays carriage and sensor for every position; junk strobes land in MOVE/SETTLE.
    task automatic drive_scan(input bit junk, input bit poke, output bit ok);
        bit got;
        ok = 1'b1;
        for (int p = 0; p < NP; p++) begin
            wait_move_req(got);
            if (!got) begin
                ok = 1'b0;
                return;
            end
            for (int i = 0; i < 3; i++) begin
                @(posedge clock);
                #1;
                if (junk) begin
                    set_junk();
                    sample_valid = 1'b1;
                end
                start = (poke && p == 1 && i == 0);
            end
            move_done = 1'b1;
            @(posedge clock);
            #1 move_done = 1'b0;
            sample_valid = junk;
            @(posedge clock);
            #1 sample_valid = 1'b0;
            repeat (ST + 3) @(posedge clock);
            #1;
            for (int k = 0; k < NS; k++) begin
                set_samples(p, k);
                sample_valid = 1'b1;
                @(posedge clock);
                #1 sample_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
    endtask

    task automatic run_scan(input bit junk, input bit poke, output bit ok);
        clear_logs();
        pulse_start();
        drive_scan(junk, poke, ok);
        if (ok) wait_done(ok);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({busy, done, error, move_req, res_we} !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, error, move_req, res_we});
        end
        n_cmp++;
        if ({move_pos, res_addr, res_data} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_pos_addr_data: got %h expected 0", {move_pos, res_addr, res_data});
        end
        n_cmp++;
        if ({tr_r_edge, tr_g_edge, tr_b_edge, tr_r_corner, tr_g_corner, tr_b_corner} !== 48'd0) begin
            n_bad++;
            $display("FAIL reset_tr: got %h expected 0",
                     {tr_r_edge, tr_g_edge, tr_b_edge, tr_r_corner, tr_g_corner, tr_b_corner});
        end
        n_cmp++;
        if (tr_known_edge_color !== 3'd7) begin
            n_bad++;
            $display("FAIL reset_known: got %0d expected 7", tr_known_edge_color);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_nominal();
        bit ok;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 6; c++)
                for (int k = 0; k < NS; k++)
                    smp[p][c][k] = (c == 0) ? 8'd13 : 8'd0;
        run_scan(1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL nominal_progress: got stalled expected done"); end
        n_cmp++;
        if (mq.size() != NP) begin n_bad++; $display("FAIL nominal_moves: got %0d expected %0d", mq.size(), NP); end
        for (int i = 0; i < mq.size(); i++) begin
            n_cmp++;
            if (mq[i] != i) begin n_bad++; $display("FAIL nominal_move_pos: got %0d expected %0d", mq[i], i); end
        end
        n_cmp++;
        if (wq.size() != 2*NP) begin n_bad++; $display("FAIL nominal_writes: got %0d expected %0d", wq.size(), 2*NP); end
        for (int i = 0; i < wq.size(); i++) begin
            n_cmp++;
            if (wq[i].addr !== 4'(i) || wq[i].data !== ((i % 2 == 0) ? 3'd5 : 3'd6)) begin
                n_bad++;
                $display("FAIL nominal_write: got addr %0d data %0d expected addr %0d data %0d",
                         wq[i].addr, wq[i].data, i, (i % 2 == 0) ? 5 : 6);
            end
        end
        n_cmp++;
        if (dq.size() != 1 || wq.size() == 0 || dq[0] != wq[wq.size()-1].cyc + 1) begin
            n_bad++;
            $display("FAIL nominal_done_timing: got %0d pulses expected 1 pulse one cycle after last write", dq.size());
        end
        n_cmp++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL nominal_idle: got busy %b error %b expected 0 0", busy, error);
        end
    endtask

    task automatic test_averaging();
        bit ok;
        randomize_samples();
        for (int k = 0; k < NS; k++) begin
            smp[0][0][k] = 8'(10 + k);
            smp[1][0][k] = 8'd255;
        end
        run_scan(1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok || wq.size() != 2*NP) begin
            n_bad++;
            $display("FAIL avg_scan: got %0d writes expected %0d", wq.size(), 2*NP);
        end else begin
            n_cmp++;
            if (wq[0].avg[0] !== 8'd11 || wq[0].data !== 3'd3) begin
                n_bad++;
                $display("FAIL avg_ramp: got avg %0d data %0d expected 11 3", wq[0].avg[0], wq[0].data);
            end
            n_cmp++;
            if (wq[2].avg[0] !== 8'd255 || wq[2].data !== 3'd7 || wq[3].data !== 3'd0) begin
                n_bad++;
                $display("FAIL avg_saturate: got avg %0d edge %0d corner %0d expected 255 7 0",
                         wq[2].avg[0], wq[2].data, wq[3].data);
            end
        end
    endtask

    task automatic test_feedback();
        bit ok;
        randomize_samples();
        for (int p = 0; p < 2; p++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 31) * 8 + 2);
            for (int k = 0; k < NS; k++) smp[p][0][k] = v;
        end
        build_model();
        run_scan(1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok || wq.size() != 2*NP) begin
            n_bad++;
            $display("FAIL fb_scan: got %0d writes expected %0d", wq.size(), 2*NP);
        end else begin
            n_cmp++;
            if (wq[0].data !== 3'd2 || wq[1].data !== 3'd3) begin
                n_bad++;
                $display("FAIL fb_edge2: got edge %0d corner %0d expected 2 3", wq[0].data, wq[1].data);
            end
            for (int p = 0; p < NP; p++) begin
                n_cmp++;
                if (wq[2*p].kn_eval !== 3'd7 || wq[2*p].kn_now !== exp_dat[2*p] || wq[2*p+1].data !== exp_dat[2*p+1]) begin
                    n_bad++;
                    $display("FAIL fb_known: pos %0d got eval %0d corner_eval %0d corner %0d expected 7 %0d %0d",
                             p, wq[2*p].kn_eval, wq[2*p].kn_now, wq[2*p+1].data, exp_dat[2*p], exp_dat[2*p+1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int s = 0; s < 2; s++) begin
            randomize_samples();
            build_model();
            run_scan(1'b1, (s == 0), ok);
            n_cmp++;
            if (!ok || mq.size() != NP || wq.size() != 2*NP) begin
                n_bad++;
                $display("FAIL gate_scan: got %0d moves %0d writes expected %0d %0d", mq.size(), wq.size(), NP, 2*NP);
            end else begin
                for (int i = 0; i < 2*NP; i++) begin
                    n_cmp++;
                    if (wq[i].addr !== 4'(i) || wq[i].data !== exp_dat[i]) begin
                        n_bad++;
                        $display("FAIL gate_write: got addr %0d data %0d expected addr %0d data %0d",
                                 wq[i].addr, wq[i].data, i, exp_dat[i]);
                    end
                end
                for (int p = 0; p < NP; p++) begin
                    for (int c = 0; c < 6; c++) begin
                        n_cmp++;
                        if (wq[2*p].avg[c] !== exp_avg[p][c]) begin
                            n_bad++;
                            $display("FAIL gate_avg: pos %0d ch %0d got %0d expected %0d",
                                     p, c, wq[2*p].avg[c], exp_avg[p][c]);
                        end
                    end
                end
            end
        end
        repeat (10) @(posedge clock);
        #1;
        n_cmp++;
        if (tr_r_edge !== exp_avg[NP-1][0] || tr_b_corner !== exp_avg[NP-1][5] || error !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_between_scans: got %0d %0d err %b expected %0d %0d 0",
                     tr_r_edge, tr_b_corner, error, exp_avg[NP-1][0], exp_avg[NP-1][5]);
        end
    endtask

    task automatic test_reset_mid_sample();
        bit got;
        randomize_samples();
        clear_logs();
        pulse_start();
        wait_move_req(got);
        @(posedge clock);
        #1 move_done = 1'b1;
        @(posedge clock);
        #1 move_done = 1'b0;
        repeat (ST + 3) @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            set_samples(0, k);
            sample_valid = 1'b1;
            @(posedge clock);
            #1 sample_valid = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (!got || {busy, done, move_req, res_we, move_pos, res_addr, res_data} !== 14'd0 || tr_known_edge_color !== 3'd7) begin
            n_bad++;
            $display("FAIL midreset_async: got ctrl %h known %0d expected 0 7",
                     {busy, done, move_req, res_we, move_pos, res_addr, res_data}, tr_known_edge_color);
        end
        n_cmp++;
        if ({tr_r_edge, tr_g_edge, tr_b_edge, tr_r_corner, tr_g_corner, tr_b_corner} !== 48'd0) begin
            n_bad++;
            $display("FAIL midreset_tr: got %h expected 0",
                     {tr_r_edge, tr_g_edge, tr_b_edge, tr_r_corner, tr_g_corner, tr_b_corner});
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        clear_logs();
        for (int k = 2; k < NS; k++) begin
            set_samples(0, k);
            sample_valid = 1'b1;
            @(posedge clock);
            #1 sample_valid = 1'b0;
        end
        move_done = 1'b1;
        @(posedge clock);
        #1 move_done = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        n_cmp++;
        if (wq.size() != 0 || dq.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got %0d writes %0d dones busy %b expected 0 0 0", wq.size(), dq.size(), busy);
        end
    endtask

`ifdef SCAN_TIMEOUT_EN
    task automatic test_timeout();
        bit got, ok;
        int n;
        clear_logs();
        pulse_start();
        wait_move_req(got);
        n = 0;
        while (error !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        n_cmp++;
        if (!got || n != TO) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO);
        end
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if (error !== 1'b1 || busy !== 1'b0 || dq.size() != 0 || wq.size() != 0) begin
            n_bad++;
            $display("FAIL timeout_state: got err %b busy %b dones %0d writes %0d expected 1 0 0 0",
                     error, busy, dq.size(), wq.size());
        end
        randomize_samples();
        build_model();
        run_scan(1'b0, 1'b0, ok);
        n_cmp++;
        if (!ok || error !== 1'b0 || wq.size() != 2*NP || wq[2*NP-1].data !== exp_dat[2*NP-1]) begin
            n_bad++;
            $display("FAIL timeout_recover: got err %b writes %0d expected 0 %0d", error, wq.size(), 2*NP);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        start        = 1'b0;
        move_done    = 1'b0;
        sample_valid = 1'b0;
        s_r_edge     = 8'd0;
        s_g_edge     = 8'd0;
        s_b_edge     = 8'd0;
        s_r_corner   = 8'd0;
        s_g_corner   = 8'd0;
        s_b_corner   = 8'd0;
        test_reset();
        test_nominal();
        test_averaging();
        test_feedback();
        test_back_to_back();
        test_reset_mid_sample();
`ifdef SCAN_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cube_scan_sequencer.md
Name: cube_scan_sequencer

Overview:
- Sequences one face scan: commands the carriage to each sticker position, waits for settling, then averages sensor samples for the edge and corner sensors.
- Drives the colour translator in two passes: edge first, then corner with the edge result fed back as the known edge colour.
- Writes resolved colour codes into the face result memory.
- Sits between the motor/carriage controller, the sensor front end, the colour translator and the face colour store.

Parameters:
- NUM_POS, 4, sticker positions per scan (edge/corner pairs), 1..8.
- LOG2_SAMPLES, 2, log2 of samples averaged per sensor per position.
- SETTLE_CYCLES, 1000, clocks to wait after move_done before sampling, ≥1.
- TIMEOUT_CYCLES, 1000000, move timeout in clocks (used only with SCAN_TIMEOUT_EN).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin scan; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when scan completes
- error  out  1  sticky move-timeout flag (SCAN_TIMEOUT_EN only)
- move_req  out  1  one-cycle request to move carriage
- move_pos  out  3  target position, valid with move_req
- move_done  in  1  one-cycle pulse when move completes
- sample_valid  in  1  sensor sample strobe
- s_r_edge, s_g_edge, s_b_edge  in  8 each  edge sensor sample
- s_r_corner, s_g_corner, s_b_corner  in  8 each  corner sensor sample
- tr_r_edge, tr_g_edge, tr_b_edge, tr_r_corner, tr_g_corner, tr_b_corner  out  8 each  averaged values to translator
- tr_known_edge_color  out  3  known edge colour to translator
- tr_color_edge, tr_color_corner  in  3 each  translator results; registered, 1-cycle latency
- res_we  out  1  result write strobe
- res_addr  out  4  result address
- res_data  out  3  result colour code

Behaviour:
- Reset: all outputs 0, except tr_known_edge_color = 3'd7 (the translator's unknown/default branch). State IDLE, counters and accumulators 0. Reset mid-scan aborts immediately; no done, no further writes.
- IDLE:
  - start=1 → pos=0, error cleared, go MOVE.
  - start while busy is ignored.
- MOVE:
  - move_req=1 with move_pos=pos for exactly the first cycle in the state.
  - Stay until move_done=1, then go SETTLE.
  - A move_done in the same cycle as move_req is accepted.
- SETTLE: counts SETTLE_CYCLES clocks, then clears accumulators and sample count, and goes SAMPLE.
- SAMPLE:
  - Each sample_valid adds all six inputs to their own accumulators, each 8+LOG2_SAMPLES bits wide.
  - After the 2^LOG2_SAMPLES-th sample:
    - each tr_* colour output ← accumulator >> LOG2_SAMPLES (truncating);
    - tr_known_edge_color ← 3'd7;
    - go EDGE_EVAL.
  - sample_valid is ignored in every other state.
- EDGE_EVAL: 1 cycle; translator registers its inputs at the end of it.
- EDGE_CAP:
  - Capture tr_color_edge.
  - Register res_we=1, res_addr=2*pos, res_data=edge colour, so the pulse appears during the next cycle.
  - tr_known_edge_color ← edge colour.
  - Go CORNER_EVAL.
- CORNER_EVAL: 1 cycle; tr_* inputs held.
- CORNER_CAP:
  - Register res_we=1, res_addr=2*pos+1, res_data=tr_color_corner.
  - If pos==NUM_POS-1 go DONE, else pos+1 and go MOVE.
- res_we is exactly one-cycle wide per write; there are exactly 2*NUM_POS writes per scan.
- DONE: done=1 for one cycle, tr_known_edge_color ← 3'd7, go IDLE.
- tr_* colour values hold their last values between scans.

Optional Feature:
- SCAN_TIMEOUT_EN defined:
  - A counter runs in MOVE. If TIMEOUT_CYCLES clocks elapse without move_done: error ← 1 (sticky until next accepted start), go IDLE, no done, no further writes.
  - A move_done arriving in the same cycle as expiry takes priority (no error).
- SCAN_TIMEOUT_EN not defined: MOVE waits indefinitely, error tied 0, no timeout counter logic.

Test Plan:
- Bench uses a stub translator: color_edge ← r_edge[2:0], color_corner ← known_edge_color+1 (3-bit wrap), both registered, 1-cycle latency.
- Nominal scan, NUM_POS=4, LOG2_SAMPLES=2, SETTLE_CYCLES=4; constant samples r_edge=13, r_corner=0; move_done 3 cycles after each move_req:
  - 4 move_req with move_pos 0,1,2,3;
  - 8 writes at addr 0..7, edges data 5, corners data 6;
  - done one cycle after the last write; busy low afterwards.
- Averaging: r_edge samples 10,11,12,13 → tr_r_edge=11, edge write data 3. Samples 255×4 → tr_r_edge=255, no overflow.
- Known-edge feedback:
  - tr_known_edge_color=7 during EDGE_EVAL and equals the captured edge colour during CORNER_EVAL;
  - edge data 2 → corner data 3.
- Gating:
  - sample_valid pulses during MOVE and SETTLE do not change the averages;
  - start during a scan does not restart it;
  - reset asserted in SAMPLE → all outputs 0 asynchronously, no further res_we or done.
- SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=50, move_done withheld:
  - error=1 after 50 cycles in MOVE, busy=0, no done;
  - next start clears error and a normal scan completes.
